fifo_rd_drain: RTL and testbench

Read-side controller for the team's synchronous FIFO. Issues `fifo_rd_en` against the FIFO's empty flag, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents the words as a valid/ready stream to the downstream consumer. Sits between the FIFO read port and any stream sink, and guarantees no read is issued into an empty FIFO and no word is dropped under backpressure.

---
 rtl/shared_pkg.sv | 13 +
 rtl/fifo_rd_drain_if.sv | 37 +++
 rtl/drain_skid_buf.sv | 53 +++++
 rtl/fifo_rd_drain.sv | 134 +++++++++++++
 tb/tb_fifo_rd_drain.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_pkg.sv
// Shared FIFO parameters and the drain controller state type.
package shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } drain_state_e;

endpackage

// File: rtl/fifo_rd_drain_if.sv
// FIFO read port plus output valid/ready stream seen by the drain controller.
// master: the drain controller. slave: the FIFO read side and the stream sink.
interface fifo_rd_drain_if
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_WIDTH
) ();

    logic                  fifo_rd_en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_underflow;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_data_out,
        input  fifo_underflow,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_data_out,
        output fifo_underflow,
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/drain_skid_buf.sv
// Two-entry circular skid buffer: 1-bit wrapping pointers, head entry always
// visible on head_data, occupancy 0..2. Callers never push when full nor pop
// when empty.
module drain_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            occ
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] occ_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [DATA_WIDTH-1:0] data_reg;

        // Entry gi captures the pushed word when the write pointer selects it.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_reg <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= push_data;
            end
        end
    end

    // Pointers wrap naturally; push+pop in one cycle leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign occ       = occ_reg;

endmodule

// File: rtl/fifo_rd_drain.sv
// FIFO read-side drain controller: issues reads against the empty flag with a
// 2-word credit limit, lands read data in a skid buffer and presents it as a
// valid/ready stream. Optional feature macro: DRAIN_UNDERFLOW_CHECK_EN
// (discard words flagged by fifo_underflow and raise a sticky error).
module fifo_rd_drain
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 drain_en,
    fifo_rd_drain_if.master      bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_out,
    output logic                 underflow_err
);

    drain_state_e          state_reg;
    logic                  busy_reg;
    logic                  inflight_reg;
    logic [CNT_WIDTH-1:0]  words_out_reg;
    logic [1:0]            occ;
    logic [2:0]            level;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  m_valid;
    logic                  pop;
    logic                  push;
    logic                  rd_en;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && bus.m_ready;

    // Buffered plus in-flight words; a read is allowed while this, less any
    // pop happening now, stays below the two buffer entries.
    assign level = {1'b0, occ} + {2'b00, inflight_reg};
    assign rd_en = (state_reg == RUN) && !bus.fifo_empty
                   && (level < (3'd2 + {2'b00, pop}));

`ifdef DRAIN_UNDERFLOW_CHECK_EN
    logic underflow_err_reg;

    assign push = inflight_reg && !bus.fifo_underflow;

    // Sticky error: a landing word flagged by the FIFO as underflow is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_err_reg <= 1'b0;
        end else if (inflight_reg && bus.fifo_underflow) begin
            underflow_err_reg <= 1'b1;
        end
    end

    assign underflow_err = underflow_err_reg;
`else
    logic unused_underflow;

    assign unused_underflow = bus.fifo_underflow;
    assign push             = inflight_reg;
    assign underflow_err    = 1'b0;
`endif

    // Control FSM with registered busy; STOP lingers until the last read lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (drain_en) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!drain_en) begin
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    if (drain_en) begin
                        state_reg <= RUN;
                    end else if (!inflight_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // A read issued now returns data next cycle; reset drops any such word.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= 1'b0;
        end else begin
            inflight_reg <= rd_en;
        end
    end

    // Saturating count of words accepted downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            words_out_reg <= '0;
        end else if (pop && (words_out_reg != '1)) begin
            words_out_reg <= words_out_reg + CNT_WIDTH'(1);
        end
    end

    drain_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.fifo_data_out),
        .pop       (pop),
        .head_data (head_data),
        .occ       (occ)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = head_data;
    assign busy           = busy_reg;
    assign words_out      = words_out_reg;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Testbench for fifo_rd_drain: a queue-based FIFO, a stream scoreboard and a
// transaction-level model of the drain rules, a directed vector table and
// hand-written corner sequences, then randomized traffic.
module tb_fifo_rd_drain;
    import shared_pkg::*;

    localparam int DW      = FIFO_WIDTH;
    localparam int CW      = 5;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_STOP  = 2;
`ifdef DRAIN_UNDERFLOW_CHECK_EN
    localparam bit UF_CHECK = 1'b1;
`else
    localparam bit UF_CHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          drain_en = 1'b0;
    logic          busy;
    logic [CW-1:0] words_out;
    logic          underflow_err;

    fifo_rd_drain_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_drain #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .drain_en      (drain_en),
        .bus           (bus),
        .busy          (busy),
        .words_out     (words_out),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    // Environment and reference model state
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    bit            pending;
    logic [DW-1:0] pending_word;
    int            mstate;
    int            pops;
    bit            exp_err;
    bit            mon_en;
    logic [DW-1:0] first_popped;
    logic [DW-1:0] last_popped;
    bit            s_rd, s_rst, s_uf, s_drain, s_ready, s_empty, s_busy;
    int            n_checks;
    int            n_pass;

    typedef struct {
        logic          drain;
        logic          ready;
        logic          exp_rd;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_busy;
        int            exp_words;
    } vec_t;

    vec_t vec [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic flush_fifo();
        fifo_q.delete();
        bus.fifo_empty = 1'b1;
    endtask

    // One clock cycle: called at a negedge with inputs already driven.
    task automatic tick();
        bit            exp_rd;
        bit            m_pop;
        int            nstate;
        logic [DW-1:0] w;
        #1;
        s_rd    = bus.fifo_rd_en;
        s_rst   = rst;
        s_uf    = bus.fifo_underflow;
        s_drain = drain_en;
        s_ready = bus.m_ready;
        s_empty = bus.fifo_empty;
        s_busy  = busy;
        m_pop   = (exp_q.size() != 0) && s_ready;
        if (mon_en) begin
            exp_rd = (mstate == S_RUN) && (fifo_q.size() != 0)
                     && ((exp_q.size() + (pending ? 1 : 0) - (m_pop ? 1 : 0)) < 2);
            check("rd_en", s_rd, exp_rd);
            check("busy", s_busy, mstate != S_IDLE);
            check("m_valid", bus.m_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("m_data", bus.m_data, exp_q[0]);
            check("words_out", words_out, (pops > CNT_MAX) ? CNT_MAX : pops);
            check("underflow_err", underflow_err, exp_err);
        end
        @(posedge clk);
        #1;
        nstate = mstate;
        case (mstate)
            S_IDLE: if (s_drain) nstate = S_RUN;
            S_RUN:  if (!s_drain) nstate = S_STOP;
            default: begin
                if (s_drain) nstate = S_RUN;
                else if (!pending) nstate = S_IDLE;
            end
        endcase
        if (m_pop) begin
            w = exp_q.pop_front();
            pops++;
            if (pops == 1) first_popped = w;
            last_popped = w;
            $display("accept data=0x%0h count=%0d", w, pops);
        end
        if (pending && !s_rst) begin
            if (UF_CHECK && s_uf) exp_err = 1'b1;
            else exp_q.push_back(pending_word);
        end
        pending = 1'b0;
        if (s_rd && (fifo_q.size() != 0)) begin
            w = fifo_q.pop_front();
            bus.fifo_data_out = w;
            pending      = !s_rst;
            pending_word = w;
        end
        if (s_rst) begin
            exp_q.delete();
            pops    = 0;
            exp_err = 1'b0;
            nstate  = S_IDLE;
        end
        mstate = nstate;
        bus.fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drain_en = 1'b0;
        bus.m_ready = 1'b0;
        bus.fifo_underflow = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int run, nrd;
        bit ended;
        n_checks = 0;
        n_pass   = 0;
        bus.fifo_empty     = 1'b1;
        bus.fifo_data_out  = '0;
        bus.fifo_underflow = 1'b0;
        bus.m_ready        = 1'b0;
        pending = 1'b0;
        pending_word = '0;
        mstate  = S_IDLE;
        pops    = 0;
        exp_err = 1'b0;
        mon_en  = 1'b0;

        //                drain ready rd  valid data     busy words
        vec[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 0};
        vec[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 0};
        vec[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 0};
        vec[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00A1, 1'b1, 0};
        vec[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h00A2, 1'b1, 1};
        vec[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h00A3, 1'b1, 2};
        vec[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3};

        // Reset with three words waiting in the FIFO
        load(16'h00A1);
        load(16'h00A2);
        load(16'h00A3);
        tick();
        mon_en = 1'b1;
        tick();
        #1;
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_words_out", words_out, 0);
        check("rst_underflow_err", underflow_err, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drain_en    = vec[i].drain;
            bus.m_ready = vec[i].ready;
            #1;
            check($sformatf("vec%0d_rd_en", i), bus.fifo_rd_en, vec[i].exp_rd);
            check($sformatf("vec%0d_m_valid", i), bus.m_valid, vec[i].exp_valid);
            check($sformatf("vec%0d_busy", i), busy, vec[i].exp_busy);
            check($sformatf("vec%0d_words_out", i), words_out, vec[i].exp_words);
            if (vec[i].exp_valid) check($sformatf("vec%0d_m_data", i), bus.m_data, vec[i].exp_data);
            tick();
        end

        // Full FIFO drained at one word per cycle
        do_reset();
        flush_fifo();
        for (int i = 0; i < FIFO_DEPTH; i++) load(DW'(16'h1000 + i));
        drain_en = 1'b1;
        bus.m_ready = 1'b1;
        run = 0;
        ended = 1'b0;
        for (int c = 0; c < 60 && !ended; c++) begin
            tick();
            if (s_rd) run++;
            else if (run > 0) begin
                ended = 1'b1;
                check("depth_rd_drop_on_empty", s_empty, 1);
            end
        end
        check("depth_rd_end_seen", ended, 1);
        check("depth_rd_run_len", run, FIFO_DEPTH);
        repeat (4) tick();
        check("depth_words_out", words_out, FIFO_DEPTH);

        // Backpressure: two reads only, head word held
        do_reset();
        flush_fifo();
        drain_en = 1'b1;
        for (int i = 0; i < 5; i++) load(DW'(16'h00B0 + i));
        nrd = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_rd) nrd++;
        end
        check("bp_reads", nrd, 2);
        check("bp_fifo_left", fifo_q.size(), 3);
        check("bp_valid", bus.m_valid, 1);
        check("bp_data_held", bus.m_data, 16'h00B0);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 40 && pops < 5; c++) tick();
        check("bp_delivered", pops, 5);
        check("bp_last_word", last_popped, 16'h00B4);

        // drain_en dropped with a read in flight
        do_reset();
        flush_fifo();
        drain_en = 1'b1;
        bus.m_ready = 1'b1;
        load(16'h00C0);
        load(16'h00C1);
        load(16'h00C2);
        tick();
        tick();
        check("stop_rd_issued", s_rd, 1);
        drain_en = 1'b0;
        tick();
        nrd = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) check("stop_busy", s_busy, 1);
            if (s_rd) nrd++;
        end
        check("stop_no_reads", nrd, 0);
        check("stop_idle", busy, 0);
        check("stop_delivered", pops, 2);
        check("stop_fifo_left", fifo_q.size(), 1);

        // Reset with buffer and read pipe both holding words
        do_reset();
        flush_fifo();
        drain_en = 1'b1;
        for (int i = 0; i < 5; i++) load(DW'(16'h00D0 + i));
        tick();
        tick();
        tick();
        #1;
        check("rstmid_pre_valid", bus.m_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_valid_cleared", bus.m_valid, 0);
        check("rstmid_data_cleared", bus.m_data, 0);
        bus.m_ready = 1'b1;
        for (int c = 0; c < 40 && pops < 3; c++) tick();
        check("rstmid_delivered", pops, 3);
        check("rstmid_first_word", first_popped, 16'h00D2);

        // Underflow flagged on the cycle a read lands
        do_reset();
        flush_fifo();
        drain_en = 1'b1;
        bus.m_ready = 1'b1;
        load(16'h00E0);
        tick();
        tick();
        bus.fifo_underflow = 1'b1;
        tick();
        bus.fifo_underflow = 1'b0;
        repeat (4) tick();
`ifdef DRAIN_UNDERFLOW_CHECK_EN
        check("uf_err_set", underflow_err, 1);
        check("uf_words_unchanged", words_out, 0);
        check("uf_no_valid", bus.m_valid, 0);
`else
        check("uf_err_tied", underflow_err, 0);
        check("uf_word_delivered", words_out, 1);
`endif

        // Randomized traffic against the model
        do_reset();
        flush_fifo();
        for (int c = 0; c < 1500; c++) begin
            if ((fifo_q.size() < FIFO_DEPTH) && ($urandom_range(0, 2) != 0)) load(DW'($urandom));
            bus.m_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) drain_en = !drain_en;
            bus.fifo_underflow = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        drain_en = 1'b0;
        bus.fifo_underflow = 1'b0;
        bus.m_ready = 1'b1;
        repeat (10) tick();
        check("final_drained", bus.m_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
